in_order_dispatch: RTL and testbench
====================================

IN_ORDER_DISPATCH -- requirements
Module: in_order_dispatch

Interface
REQ-001 Parameter entryWidth, default 302, SHALL set the width in bits of one in-order queue entry.
REQ-002 Parameter robTagBits, default 6, SHALL set the ROB tag width; ROB depth = 2**robTagBits.
REQ-003 clock_i  in  1  SHALL be the single clock; all state updates on posedge.
REQ-004 reset_i  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 queueEmpty_i  in  1  SHALL carry the in-order queue empty flag.
REQ-006 queueReadEnable_o  out  1  SHALL be the dequeue request to the in-order queue.
REQ-007 queueEntry_i  in  entryWidth  SHALL carry the dequeued entry, valid one cycle after a sampled dequeue request.
REQ-008 flush_i  in  1  SHALL be the synchronous pipeline flush.
REQ-009 robRelease_i  in  1  SHALL pulse once per ROB entry retired.
REQ-010 dispatchValid_o  out  1  SHALL mark dispatchEntry_o/dispatchTag_o as valid.
REQ-011 dispatchReady_i  in  1  SHALL be the downstream accept signal.
REQ-012 dispatchEntry_o  out  entryWidth  SHALL carry the dispatched entry.
REQ-013 dispatchTag_o  out  robTagBits  SHALL carry the ROB tag of the dispatched entry.
REQ-014 robCredits_o  out  robTagBits+1  SHALL report free ROB entries.
REQ-015 stall_o  out  1  SHALL flag a credit stall.
REQ-016 creditError_o  out  1  SHALL be a sticky flag for a release while credits are already full.
REQ-017 dispatchCount_o  out  32  SHALL count completed dispatches.

Function
REQ-018 The FSM SHALL have states IDLE, READ, CAPTURE, SEND.
REQ-019 IDLE->READ SHALL occur when queueEmpty_i=0, credits>0 and flush_i=0; otherwise the FSM SHALL stay in IDLE.
REQ-020 queueReadEnable_o SHALL be registered and high exactly during the single READ cycle.
REQ-021 READ->CAPTURE SHALL be unconditional.
REQ-022 In CAPTURE, the block SHALL latch queueEntry_i into dispatchEntry_o and the current tag into dispatchTag_o, then enter SEND.
REQ-023 In SEND, dispatchValid_o=1 and entry/tag SHALL hold stable until dispatchValid_o&&dispatchReady_i at a clock edge.
REQ-024 On a SEND handshake, the FSM SHALL go to READ if the REQ-019 conditions hold (back-to-back), else to IDLE.
REQ-025 Minimum dispatch interval SHALL be 3 cycles; latency from IDLE->READ to dispatchValid_o SHALL be 2 cycles.
REQ-026 Credits SHALL decrement by 1 on each entry into READ and increment by 1 on robRelease_i.
REQ-027 A simultaneous decrement and release SHALL leave credits unchanged.
REQ-028 A release at credits=2**robTagBits SHALL leave credits unchanged and set creditError_o.
REQ-029 The tag counter SHALL increment on each handshake, modulo 2**robTagBits (63->0 at default).
REQ-030 stall_o SHALL be combinational: high when state is IDLE, queueEmpty_i=0 and credits=0.
REQ-031 dispatchCount_o SHALL increment on each handshake and wrap at 2**32.
REQ-032 flush_i SHALL take priority over every other event: the FSM goes to IDLE, dispatchValid_o and queueReadEnable_o go to 0, credits return to 2**robTagBits, tag returns to 0.
REQ-033 Under flush, any entry in READ/CAPTURE SHALL be discarded, and a handshake coinciding with flush SHALL NOT be counted.
REQ-034 Under flush, creditError_o and dispatchCount_o SHALL be kept.

Reset
REQ-035 While reset_i=0, the block SHALL asynchronously force: state IDLE, queueReadEnable_o=0, dispatchValid_o=0, dispatchEntry_o=0, dispatchTag_o=0, tag=0, robCredits_o=2**robTagBits, creditError_o=0, dispatchCount_o=0.
REQ-036 Reset asserted mid-operation SHALL abandon any in-flight entry.
REQ-037 The first possible READ SHALL occur on the first edge after reset_i rises.

Verification
REQ-038 Single entry: queue holds 0xABC, ready=1 -> queueReadEnable_o high 1 cycle; dispatchValid_o 2 cycles later with entry 0xABC, tag 0; credits 64->63; count 1.
REQ-039 Back-to-back: 3 entries queued, ready=1 -> tags 0,1,2 at 3-cycle spacing; credits 61.
REQ-040 Backpressure: ready=0 for 5 cycles in SEND -> entry/tag stable; no queueReadEnable_o pulse; transfer occurs on the first ready=1 edge.
REQ-041 Credit exhaustion: 64 dispatches with no releases -> stall_o=1 with queue non-empty; one robRelease_i pulse -> READ on the next edge; tag wraps 63->0.
REQ-042 Simultaneous/overflow: release coincides with READ -> credits unchanged; release at 64 credits -> creditError_o=1 and stays set.
REQ-043 Flush in CAPTURE, and async reset in SEND -> no dispatchValid_o for that entry, credits 64, tag 0, state IDLE.

Source files
------------

// File: rtl/in_order_dispatch.sv
// In-order dispatch stage: pulls entries from an in-order queue, tags them with a ROB tag
// and hands them downstream under ROB credit flow control.
module in_order_dispatch #(
    parameter int unsigned entryWidth = 302,
    parameter int unsigned robTagBits = 6
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  queueEmpty_i,
    output logic                  queueReadEnable_o,
    input  logic [entryWidth-1:0] queueEntry_i,
    input  logic                  flush_i,
    input  logic                  robRelease_i,
    output logic                  dispatchValid_o,
    input  logic                  dispatchReady_i,
    output logic [entryWidth-1:0] dispatchEntry_o,
    output logic [robTagBits-1:0] dispatchTag_o,
    output logic [robTagBits:0]   robCredits_o,
    output logic                  stall_o,
    output logic                  creditError_o,
    output logic [31:0]           dispatchCount_o
);

    localparam logic [robTagBits:0] CreditsFull = {1'b1, {robTagBits{1'b0}}};

    typedef enum logic [1:0] {StIdle, StRead, StCapture, StSend} state_e;

    state_e                  state_q, state_d;
    logic                    read_en_q;
    logic                    valid_q;
    logic [entryWidth-1:0]   entry_q;
    logic [robTagBits-1:0]   dtag_q;
    logic [robTagBits-1:0]   tag_q, tag_d;
    logic [robTagBits:0]     credits_q, credits_d;
    logic                    error_q, error_d;
    logic [31:0]             count_q, count_d;

    logic go;
    logic handshake;
    logic enter_read;
    logic capture;

    always_comb begin
        go         = !queueEmpty_i && (credits_q != '0) && !flush_i;
        handshake  = (state_q == StSend) && dispatchReady_i;
        capture    = (state_q == StCapture) && !flush_i;
        state_d    = state_q;

        unique case (state_q)
            StIdle:    if (go) state_d = StRead;
            StRead:    state_d = StCapture;
            StCapture: state_d = StSend;
            StSend:    if (dispatchReady_i) state_d = go ? StRead : StIdle;
            default:   state_d = StIdle;
        endcase
        if (flush_i) state_d = StIdle;

        // READ is never re-entered from itself, so any next-state READ is a fresh entry.
        enter_read = (state_d == StRead);

        credits_d = credits_q;
        error_d   = error_q;
        if (flush_i) begin
            credits_d = CreditsFull;
        end else if (enter_read && !robRelease_i) begin
            credits_d = credits_q - 1'b1;
        end else if (!enter_read && robRelease_i) begin
            if (credits_q == CreditsFull) error_d = 1'b1;
            else                          credits_d = credits_q + 1'b1;
        end

        tag_d   = tag_q;
        count_d = count_q;
        if (flush_i) begin
            tag_d = '0;
        end else if (handshake) begin
            tag_d   = tag_q + 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= StIdle;
            read_en_q <= 1'b0;
            valid_q   <= 1'b0;
            entry_q   <= '0;
            dtag_q    <= '0;
            tag_q     <= '0;
            credits_q <= CreditsFull;
            error_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            read_en_q <= (state_d == StRead);
            valid_q   <= (state_d == StSend);
            tag_q     <= tag_d;
            credits_q <= credits_d;
            error_q   <= error_d;
            count_q   <= count_d;
            if (capture) begin
                entry_q <= queueEntry_i;
                dtag_q  <= tag_q;
            end
        end
    end

    assign queueReadEnable_o = read_en_q;
    assign dispatchValid_o   = valid_q;
    assign dispatchEntry_o   = entry_q;
    assign dispatchTag_o     = dtag_q;
    assign robCredits_o      = credits_q;
    assign creditError_o     = error_q;
    assign dispatchCount_o   = count_q;
    assign stall_o           = (state_q == StIdle) && !queueEmpty_i && (credits_q == '0);

endmodule

// File: tb/tb_in_order_dispatch.sv
// Bench for in_order_dispatch: queue model, per-cycle reference model and directed scenarios.
module tb_in_order_dispatch;

    localparam int unsigned EW   = 302;
    localparam int unsigned TB   = 6;
    localparam int          FULL = 64;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          q_empty;
    logic          rd_en;
    logic [EW-1:0] q_entry = '0;
    logic          flush;
    logic          rel;
    logic          valid;
    logic          ready;
    logic [EW-1:0] d_entry;
    logic [TB-1:0] d_tag;
    logic [TB:0]   credits;
    logic          stall;
    logic          err;
    logic [31:0]   count;

    in_order_dispatch #(.entryWidth(EW), .robTagBits(TB)) dut (
        .clock_i          (clock),
        .reset_i          (reset_n),
        .queueEmpty_i     (q_empty),
        .queueReadEnable_o(rd_en),
        .queueEntry_i     (q_entry),
        .flush_i          (flush),
        .robRelease_i     (rel),
        .dispatchValid_o  (valid),
        .dispatchReady_i  (ready),
        .dispatchEntry_o  (d_entry),
        .dispatchTag_o    (d_tag),
        .robCredits_o     (credits),
        .stall_o          (stall),
        .creditError_o    (err),
        .dispatchCount_o  (count)
    );

    always #5 clock = ~clock;

    // External in-order queue: data appears the cycle after a sampled read request.
    logic [EW-1:0] qmem [0:511];
    int n_push = 0;
    int n_pop  = 0;
    assign q_empty = (n_push == n_pop);
    always @(posedge clock) begin
        if (rd_en) begin
            q_entry <= qmem[n_pop];
            n_pop   <= n_pop + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_age is cycles since the entry's read (-1 none, 0 read, 1 capture, 2 send).
    int            m_age;
    int            m_credits;
    int            m_tag;
    int            m_dtag;
    int            m_rd = 0;
    logic [31:0]   m_count;
    logic          m_err;
    logic [EW-1:0] m_entry;
    bit            m_go;
    bit            m_dec;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_age = -1; m_credits = FULL; m_tag = 0; m_dtag = 0;
            m_count = '0; m_err = 1'b0; m_entry = '0;
        end else begin
            if (m_age == 0) m_rd++;
            if (!flush && m_age == 1) begin
                m_entry = qmem[m_rd-1];
                m_dtag  = m_tag;
            end
            if (flush) begin
                m_age = -1; m_credits = FULL; m_tag = 0;
            end else begin
                m_go  = !q_empty && m_credits > 0;
                m_dec = 1'b0;
                if (m_age == -1) begin
                    if (m_go) begin m_age = 0; m_dec = 1'b1; end
                end else if (m_age < 2) begin
                    m_age++;
                end else if (ready) begin
                    m_count = m_count + 32'd1;
                    m_tag   = (m_tag + 1) % FULL;
                    if (m_go) begin m_age = 0; m_dec = 1'b1; end
                    else m_age = -1;
                end
                if (rel && !m_dec) begin
                    if (m_credits == FULL) m_err = 1'b1;
                    else m_credits++;
                end else if (m_dec && !rel) begin
                    m_credits--;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("read_enable", 320'(rd_en),   320'(m_age == 0));
        check("valid",       320'(valid),   320'(m_age == 2));
        check("credits",     320'(credits), 320'(m_credits));
        check("stall",       320'(stall),   320'(m_age == -1 && !q_empty && m_credits == 0));
        check("cred_error",  320'(err),     320'(m_err));
        check("count",       320'(count),   320'(m_count));
        check("entry",       320'(d_entry), 320'(m_entry));
        check("tag",         320'(d_tag),   320'(m_dtag));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic push(input logic [EW-1:0] v);
        qmem[n_push] = v;
        n_push++;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; rel = 1'b0; ready = 1'b1;
        cyc(2);
        push(302'hABC);
        cyc(1);
        check("rst_credits", 320'(credits), 320'(64));
        check("rst_rd_en",   320'(rd_en),   320'(0));
        check("rst_count",   320'(count),   320'(0));

        // Single entry, first read right after reset release.
        reset_n = 1'b1;
        cyc(1);
        check("single_rd_en",   320'(rd_en),   320'(1));
        check("single_credits", 320'(credits), 320'(63));
        cyc(2);
        check("single_valid", 320'(valid),   320'(1));
        check("single_entry", 320'(d_entry), 320'(302'hABC));
        check("single_tag",   320'(d_tag),   320'(0));
        cyc(1);
        check("single_count", 320'(count), 320'(1));

        // Back-to-back at 3-cycle spacing.
        cyc(2);
        do_flush();
        push(302'hA1); push(302'hA2); push(302'hA3);
        cyc(3);
        check("b2b_tag0", 320'(d_tag), 320'(0));
        cyc(3);
        check("b2b_tag1", 320'(d_tag), 320'(1));
        cyc(3);
        check("b2b_tag2",    320'(d_tag),   320'(2));
        check("b2b_entry2",  320'(d_entry), 320'(302'hA3));
        check("b2b_credits", 320'(credits), 320'(61));
        cyc(3);

        // Backpressure: entry held, no new read while stalled downstream.
        ready = 1'b0;
        push(302'hB1);
        cyc(3);
        push(302'hB2);
        cyc(5);
        check("bp_valid", 320'(valid),   320'(1));
        check("bp_entry", 320'(d_entry), 320'(302'hB1));
        check("bp_rd_en", 320'(rd_en),   320'(0));
        ready = 1'b1;
        cyc(1);
        check("bp_count", 320'(count), 320'(5));
        check("bp_next",  320'(rd_en), 320'(1));
        cyc(5);

        // Credit exhaustion and tag wrap.
        do_flush();
        for (int i = 0; i < 65; i++) push(302'(32'h1000 + i));
        cyc(200);
        check("ex_stall",   320'(stall),   320'(1));
        check("ex_credits", 320'(credits), 320'(0));
        check("ex_count",   320'(count),   320'(70));
        rel = 1'b1;
        cyc(1);
        rel = 1'b0;
        check("ex_rel_credits", 320'(credits), 320'(1));
        check("ex_rel_stall",   320'(stall),   320'(0));
        cyc(1);
        check("ex_rd_en", 320'(rd_en), 320'(1));
        cyc(2);
        check("ex_wrap_tag",   320'(d_tag),   320'(0));
        check("ex_wrap_entry", 320'(d_entry), 320'(302'h1040));
        cyc(2);

        // Release at full credits, then release coinciding with a read.
        do_flush();
        rel = 1'b1;
        cyc(1);
        rel = 1'b0;
        check("ovf_error",   320'(err),     320'(1));
        check("ovf_credits", 320'(credits), 320'(64));
        push(302'hC1);
        rel = 1'b1;
        cyc(1);
        rel = 1'b0;
        check("sim_rd_en",   320'(rd_en),   320'(1));
        check("sim_credits", 320'(credits), 320'(64));
        cyc(5);
        do_flush();
        check("flush_keeps_error", 320'(err),   320'(1));
        check("flush_keeps_count", 320'(count), 320'(72));

        // Flush during capture discards the entry; flush on a handshake is not counted.
        push(302'hD1);
        cyc(2);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        check("fc_valid",   320'(valid),   320'(0));
        check("fc_credits", 320'(credits), 320'(64));
        cyc(3);
        push(302'hD2);
        cyc(3);
        check("fc_next_entry", 320'(d_entry), 320'(302'hD2));
        check("fc_next_tag",   320'(d_tag),   320'(0));
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        check("fh_count", 320'(count), 320'(72));
        check("fh_valid", 320'(valid), 320'(0));
        cyc(2);

        // Asynchronous reset while an entry waits in SEND.
        ready = 1'b0;
        push(302'hE1);
        cyc(3);
        check("ar_pre_valid", 320'(valid), 320'(1));
        #1 reset_n = 1'b0;
        #1;
        check("ar_valid",   320'(valid),   320'(0));
        check("ar_credits", 320'(credits), 320'(64));
        check("ar_entry",   320'(d_entry), 320'(0));
        check("ar_count",   320'(count),   320'(0));
        cyc(1);
        reset_n = 1'b1;
        ready = 1'b1;
        cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
